// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS tuning word from start to stop with a programmable
// dwell per value, in single, sawtooth, triangle or hold modes.
module dds_sweep_ctrl #(
    parameter int unsigned FTW_W   = 16,
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [FTW_W-1:0]   ftw_start,
    input  logic [FTW_W-1:0]   ftw_stop,
    input  logic [FTW_W-1:0]   ftw_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [FTW_W-1:0]   ftw,
    output logic               ftw_load,
    output logic               busy,
    output logic               done,
    output logic               dir,
    output logic               err
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;
    typedef enum logic [1:0] {ModeSingle, ModeSaw, ModeTri, ModeHold} mode_e;

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [FTW_W-1:0]   start_q, start_d;
    logic [FTW_W-1:0]   stop_q, stop_d;
    logic [FTW_W-1:0]   step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [FTW_W-1:0]   ftw_q, ftw_d;
    logic               ftw_load_q, ftw_load_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dir_q, dir_d;
    logic               err_q, err_d;

    // Extra bit on both paths catches carry-out / borrow so the result clamps instead of wrapping.
    logic [FTW_W:0]   up_sum;
    logic [FTW_W:0]   dn_diff;
    logic [FTW_W-1:0] up_val;
    logic [FTW_W-1:0] dn_val;

    assign up_sum  = {1'b0, ftw_q} + {1'b0, step_q};
    assign dn_diff = {1'b0, ftw_q} - {1'b0, step_q};
    assign up_val  = (up_sum[FTW_W] || (up_sum[FTW_W-1:0] > stop_q)) ? stop_q
                                                                       : up_sum[FTW_W-1:0];
    assign dn_val  = (dn_diff[FTW_W] || (dn_diff[FTW_W-1:0] < start_q)) ? start_q
                                                                          : dn_diff[FTW_W-1:0];

    logic [FTW_W-1:0] adv_ftw;
    logic             adv_dir;
    logic             adv_done;

    // Value and direction the sweep moves to at the end of the current dwell.
    always_comb begin
        adv_ftw  = ftw_q;
        adv_dir  = dir_q;
        adv_done = 1'b0;
        if (mode_q != ModeHold) begin
            if (!dir_q) begin
                if (ftw_q < stop_q) begin
                    adv_ftw = up_val;
                end else begin
                    case (mode_q)
                        ModeSingle: adv_done = 1'b1;
                        ModeSaw:    adv_ftw  = start_q;
                        ModeTri: begin
                            adv_dir = 1'b1;
                            adv_ftw = dn_val;
                        end
                        default: adv_ftw = ftw_q;
                    endcase
                end
            end else begin
                if (ftw_q > start_q) begin
                    adv_ftw = dn_val;
                end else begin
                    adv_dir = 1'b0;
                    adv_ftw = up_val;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        start_d    = start_q;
        stop_d     = stop_q;
        step_d     = step_q;
        dwell_d    = dwell_q;
        cnt_d      = cnt_q;
        ftw_d      = ftw_q;
        ftw_load_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dir_d      = dir_q;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    if (ftw_stop < ftw_start) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d     = mode_e'(mode);
                        start_d    = ftw_start;
                        stop_d     = ftw_stop;
                        step_d     = ftw_step;
                        dwell_d    = dwell;
                        cnt_d      = '0;
                        ftw_d      = ftw_start;
                        ftw_load_d = 1'b1;
                        busy_d     = 1'b1;
                        dir_d      = 1'b0;
                        state_d    = StRun;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (cnt_q == dwell_q) begin
                    cnt_d = '0;
                    if (adv_done) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ftw_d      = adv_ftw;
                        dir_d      = adv_dir;
                        ftw_load_d = (adv_ftw != ftw_q);
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= ModeSingle;
            start_q    <= '0;
            stop_q     <= '0;
            step_q     <= '0;
            dwell_q    <= '0;
            cnt_q      <= '0;
            ftw_q      <= '0;
            ftw_load_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            step_q     <= step_d;
            dwell_q    <= dwell_d;
            cnt_q      <= cnt_d;
            ftw_q      <= ftw_d;
            ftw_load_q <= ftw_load_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
        end
    end

    assign ftw      = ftw_q;
    assign ftw_load = ftw_load_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign dir      = dir_q;
    assign err      = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: per-cycle vector table plus a long-dwell timing sequence.
module tb_dds_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [15:0] ftw_start;
    logic [15:0] ftw_stop;
    logic [15:0] ftw_step;
    logic [15:0] dwell;
    logic [15:0] ftw;
    logic        ftw_load;
    logic        busy;
    logic        done;
    logic        dir;
    logic        err;

    dds_sweep_ctrl #(
        .FTW_W  (16),
        .DWELL_W(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .mode     (mode),
        .ftw_start(ftw_start),
        .ftw_stop (ftw_stop),
        .ftw_step (ftw_step),
        .dwell    (dwell),
        .ftw      (ftw),
        .ftw_load (ftw_load),
        .busy     (busy),
        .done     (done),
        .dir      (dir),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        start;
        logic        abort;
        logic [1:0]  mode;
        logic [15:0] s;
        logic [15:0] p;
        logic [15:0] st;
        logic [15:0] dw;
        logic [15:0] e_ftw;
        logic        e_ld;
        logic        e_busy;
        logic        e_done;
        logic        e_dir;
        logic        e_err;
    } vec_t;

    vec_t        tbl[$];
    logic [1:0]  c_mode;
    logic [15:0] c_s, c_p, c_st, c_dw;
    int          checks;
    int          failures;

    task automatic cfg(input logic [1:0] m, input logic [15:0] s, input logic [15:0] p,
                       input logic [15:0] st, input logic [15:0] dw);
        c_mode = m;
        c_s    = s;
        c_p    = p;
        c_st   = st;
        c_dw   = dw;
    endtask

    // Inputs applied before an edge, outputs expected just after it.
    task automatic add(input logic r, input logic sa, input logic ab, input logic [15:0] e_ftw,
                       input logic ld, input logic b, input logic dn, input logic d,
                       input logic e);
        vec_t v;
        v.rst = r;   v.start = sa; v.abort = ab;
        v.mode = c_mode; v.s = c_s; v.p = c_p; v.st = c_st; v.dw = c_dw;
        v.e_ftw = e_ftw; v.e_ld = ld; v.e_busy = b; v.e_done = dn; v.e_dir = d; v.e_err = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int n;
    int loads;

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
        ftw_start = '0; ftw_stop = '0; ftw_step = '0; dwell = '0;

        // Reset state
        cfg(0, 100, 400, 100, 2);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Single sweep 100..400, dwell 2; config changes and a start mid-run are ignored
        add(0, 1, 0, 100, 1, 1, 0, 0, 0);
        add(0, 0, 0, 100, 0, 1, 0, 0, 0);
        add(0, 0, 0, 100, 0, 1, 0, 0, 0);
        add(0, 0, 0, 200, 1, 1, 0, 0, 0);
        cfg(1, 5, 9, 1, 0);
        add(0, 0, 0, 200, 0, 1, 0, 0, 0);
        add(0, 0, 0, 200, 0, 1, 0, 0, 0);
        add(0, 0, 0, 300, 1, 1, 0, 0, 0);
        add(0, 1, 0, 300, 0, 1, 0, 0, 0);
        add(0, 0, 0, 300, 0, 1, 0, 0, 0);
        add(0, 0, 0, 400, 1, 1, 0, 0, 0);
        add(0, 0, 0, 400, 0, 1, 0, 0, 0);
        add(0, 0, 0, 400, 0, 1, 0, 0, 0);
        add(0, 0, 0, 400, 0, 0, 1, 0, 0);
        // Clamp at carry-out, started in the done cycle
        cfg(0, 16'hFF00, 16'hFFFF, 16'h0080, 0);
        add(0, 1, 0, 16'hFF00, 1, 1, 0, 0, 0);
        add(0, 0, 0, 16'hFF80, 1, 1, 0, 0, 0);
        add(0, 0, 0, 16'hFFFF, 1, 1, 0, 0, 0);
        add(0, 0, 0, 16'hFFFF, 0, 0, 1, 0, 0);
        // Triangle 10..30 step 10, abort overriding an advance
        cfg(2, 10, 30, 10, 0);
        add(0, 1, 0, 10, 1, 1, 0, 0, 0);
        add(0, 0, 0, 20, 1, 1, 0, 0, 0);
        add(0, 0, 0, 30, 1, 1, 0, 0, 0);
        add(0, 0, 0, 20, 1, 1, 0, 1, 0);
        add(0, 0, 0, 10, 1, 1, 0, 1, 0);
        add(0, 0, 0, 20, 1, 1, 0, 0, 0);
        add(0, 0, 0, 30, 1, 1, 0, 0, 0);
        add(0, 0, 1, 30, 0, 0, 0, 0, 0);
        // Sawtooth
        cfg(1, 10, 30, 10, 0);
        add(0, 1, 0, 10, 1, 1, 0, 0, 0);
        add(0, 0, 0, 20, 1, 1, 0, 0, 0);
        add(0, 0, 0, 30, 1, 1, 0, 0, 0);
        add(0, 0, 0, 10, 1, 1, 0, 0, 0);
        add(0, 0, 0, 20, 1, 1, 0, 0, 0);
        add(0, 0, 1, 20, 0, 0, 0, 0, 0);
        // Abort during the 200 dwell with a simultaneous start; no done afterwards
        cfg(0, 100, 400, 100, 2);
        add(0, 1, 0, 100, 1, 1, 0, 0, 0);
        add(0, 0, 0, 100, 0, 1, 0, 0, 0);
        add(0, 0, 0, 100, 0, 1, 0, 0, 0);
        add(0, 0, 0, 200, 1, 1, 0, 0, 0);
        add(0, 1, 1, 200, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 200, 0, 0, 0, 0, 0);
        add(0, 1, 1, 200, 0, 0, 0, 0, 0);
        add(0, 0, 0, 200, 0, 0, 0, 0, 0);
        // Bad config: err pulse only
        cfg(0, 60, 50, 1, 0);
        add(0, 1, 0, 200, 0, 0, 0, 0, 1);
        add(0, 0, 0, 200, 0, 0, 0, 0, 0);
        // step=0, start!=stop: runs without loads until abort
        cfg(0, 5, 9, 0, 0);
        add(0, 1, 0, 5, 1, 1, 0, 0, 0);
        add(0, 0, 0, 5, 0, 1, 0, 0, 0);
        add(0, 0, 0, 5, 0, 1, 0, 0, 0);
        add(0, 0, 0, 5, 0, 1, 0, 0, 0);
        add(0, 0, 1, 5, 0, 0, 0, 0, 0);
        // start==stop single: one dwell then done
        cfg(0, 7, 7, 3, 1);
        add(0, 1, 0, 7, 1, 1, 0, 0, 0);
        add(0, 0, 0, 7, 0, 1, 0, 0, 0);
        add(0, 0, 0, 7, 0, 0, 1, 0, 0);
        // Hold mode
        cfg(3, 40, 90, 5, 0);
        add(0, 1, 0, 40, 1, 1, 0, 0, 0);
        add(0, 0, 0, 40, 0, 1, 0, 0, 0);
        add(0, 0, 0, 40, 0, 1, 0, 0, 0);
        add(0, 0, 0, 40, 0, 1, 0, 0, 0);
        add(0, 0, 1, 40, 0, 0, 0, 0, 0);
        // Reset on the triangle down leg
        cfg(2, 10, 30, 10, 0);
        add(0, 1, 0, 10, 1, 1, 0, 0, 0);
        add(0, 0, 0, 20, 1, 1, 0, 0, 0);
        add(0, 0, 0, 30, 1, 1, 0, 0, 0);
        add(0, 0, 0, 20, 1, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; start = tbl[i].start; abort = tbl[i].abort;
            mode = tbl[i].mode; ftw_start = tbl[i].s; ftw_stop = tbl[i].p;
            ftw_step = tbl[i].st; dwell = tbl[i].dw;
            @(posedge clk);
            #1;
            check($sformatf("vec[%0d] {ftw,ld,busy,done,dir,err}", i),
                  {10'd0, ftw, ftw_load, busy, done, dir, err},
                  {10'd0, tbl[i].e_ftw, tbl[i].e_ld, tbl[i].e_busy, tbl[i].e_done,
                   tbl[i].e_dir, tbl[i].e_err});
        end

        // Long dwell: done exactly dwell+1 cycles after the start edge, no extra loads
        rst = 1'b0; abort = 1'b0; mode = 2'd0;
        ftw_start = 16'd3; ftw_stop = 16'd3; ftw_step = 16'd1; dwell = 16'd300;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("long_dwell_first_load", {30'd0, ftw_load, busy}, {30'd0, 2'b11});
        n = 0;
        loads = 0;
        while (!done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (ftw_load) loads++;
        end
        check("long_dwell_done_latency", n, 301);
        check("long_dwell_extra_loads", loads, 0);
        check("long_dwell_ftw_busy", {15'd0, ftw, busy}, {15'd0, 16'd3, 1'b0});
        @(posedge clk);
        #1;
        check("long_dwell_done_pulse_width", {31'd0, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
